// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready producer streams into one
// valid/ready output through a two-entry (main + skid) output buffer.
module rr_stream_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 16,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_src
);

    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic              active_q;
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [IDX_W-1:0]  main_src_q, main_src_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [IDX_W-1:0]  skid_src_q, skid_src_d;

    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic [DATA_W-1:0] in_data;
    logic              in_fire;
    logic              out_fire;

    // Rotating priority search: first valid requester after last_grant wins.
    always_comb begin : grant_search
        int unsigned      base;
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        base      = 32'(last_grant_q);
        cand      = 0;
        cand_idx  = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand     = (base + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_vld && req_valid[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        in_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                in_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // active_q keeps req_ready low during reset without a combinational reset path.
    always_comb begin
        req_ready = '0;
        if (active_q && grant_vld && !skid_valid_q) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign in_fire  = |(req_valid & req_ready);
    assign out_fire = main_valid_q & out_ready;

    always_comb begin
        last_grant_d = last_grant_q;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_src_d   = main_src_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_src_d   = skid_src_q;

        if (in_fire) begin
            last_grant_d = grant_idx;
        end

        if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_src_d   = skid_src_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_src_d   = grant_idx;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_src_d   = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q     <= 1'b0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_src_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_src_q   <= '0;
        end else begin
            active_q     <= 1'b1;
            last_grant_q <= last_grant_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_src_q   <= main_src_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_src_q   <= skid_src_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_src   = main_src_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed and randomized self-checking bench for rr_stream_arbiter (4 x 16-bit streams).
module tb_rr_stream_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_src;

    rr_stream_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          rem[NREQ];
    logic [15:0] nxt[NREQ];
    logic [15:0] exp_nxt[NREQ];
    int          waitc[NREQ];
    int          maxw[NREQ];
    logic [NREQ-1:0] vld;
    bit          rnd = 0;
    logic [1:0]  q_src[$];
    logic [15:0] q_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic apply();
        req_valid = vld;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = nxt[i];
    endtask

    task automatic drive_now();
        for (int i = 0; i < NREQ; i++) vld[i] = (rem[i] != 0);
        apply();
        #1;
    endtask

    // One clock: record pre-edge handshakes, advance producers, check output hold.
    task automatic cycle();
        logic [NREQ-1:0] fv;
        logic        of, hold;
        logic [15:0] pd;
        logic [1:0]  ps;
        fv   = req_valid & req_ready;
        of   = out_valid & out_ready;
        hold = out_valid & ~out_ready;
        pd   = out_data;
        ps   = out_src;
        if (rnd && fv != 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (fv[i]) waitc[i] = 0;
                else if (req_valid[i]) begin
                    waitc[i]++;
                    if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
                end
            end
        end
        if (of) begin
            q_src.push_back(out_src);
            q_data.push_back(out_data);
            if (rnd) begin
                chk("rnd_order", 32'(out_data), 32'(exp_nxt[out_src]));
                exp_nxt[out_src] = exp_nxt[out_src] + 16'd1;
            end
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (fv[i]) begin
                rem[i]--;
                nxt[i] = nxt[i] + 16'd1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rnd) begin
                if (!(req_valid[i] && !fv[i]))
                    vld[i] = (rem[i] != 0) && ($urandom_range(0, 9) < 7);
            end else begin
                vld[i] = (rem[i] != 0);
            end
        end
        apply();
        #1;
        if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(pd));
            chk("hold_src", 32'(out_src), 32'(ps));
        end
    endtask

    task automatic drain();
        int c;
        out_ready = 1'b1;
        c = 0;
        while ((rem[0] + rem[1] + rem[2] + rem[3] != 0 || out_valid) && c < 60) begin
            cycle();
            c++;
        end
        chk("drain_done", 32'(c < 60), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            nxt[i] = 16'((i + 1) << 12);
        end
        drive_now();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        q_src.delete();
        q_data.delete();
        #1;
    endtask

    initial begin
        logic [1:0]  fair_src[8];
        logic [15:0] fair_dat[8];
        logic [1:0]  skip_src[4];
        logic [15:0] skip_dat[4];
        int          c;

        // Test 1: reset behaviour, first beat, asynchronous mid-cycle reset
        reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            nxt[i] = 16'((i + 1) << 12);
        end
        #12;
        rem[0] = 1;
        drive_now();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        cycle();
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        chk("t1_out_valid0", 32'(out_valid), 32'd0);
        cycle();
        chk("t1_out_valid1", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'h1000);
        chk("t1_out_src", 32'(out_src), 32'd0);
        chk("t1_ready_idle", 32'(req_ready), 32'h0);
        rem[1] = 1;
        drive_now();
        chk("t1_ready_src1", 32'(req_ready), 32'h2);
        reset = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'h0);
        chk("async_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #2;
        chk("inrst_req_ready", 32'(req_ready), 32'h0);
        reset = 1'b1;
        cycle();
        chk("postrst_ready", 32'(req_ready), 32'h2);
        drain();
        chk("t1_q_size", 32'(q_src.size()), 32'd1);
        chk("t1_q_data", 32'(q_data[0]), 32'h2000);

        // Test 2: fairness, all four requesting, two beats each
        do_reset();
        for (int i = 0; i < NREQ; i++) rem[i] = 2;
        out_ready = 1'b1;
        drive_now();
        drain();
        fair_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        fair_dat = '{16'h1000, 16'h2000, 16'h3000, 16'h4000,
                     16'h1001, 16'h2001, 16'h3001, 16'h4001};
        chk("fair_count", 32'(q_src.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("fair_src", 32'(q_src[k]), 32'(fair_src[k]));
            chk("fair_data", 32'(q_data[k]), 32'(fair_dat[k]));
        end

        // Test 3: idle sources 0 and 2 are skipped
        do_reset();
        rem[1] = 2;
        rem[3] = 2;
        out_ready = 1'b1;
        drive_now();
        drain();
        skip_src = '{2'd1, 2'd3, 2'd1, 2'd3};
        skip_dat = '{16'h2000, 16'h4000, 16'h2001, 16'h4001};
        chk("skip_count", 32'(q_src.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("skip_src", 32'(q_src[k]), 32'(skip_src[k]));
            chk("skip_data", 32'(q_data[k]), 32'(skip_dat[k]));
        end

        // Test 4: backpressure fills main + skid, then releases in order
        do_reset();
        nxt[2] = 16'h00A0;
        rem[2] = 6;
        out_ready = 1'b0;
        drive_now();
        chk("bp_ready0", 32'(req_ready), 32'h4);
        cycle();
        chk("bp_data0", 32'(out_data), 32'h00A0);
        chk("bp_ready1", 32'(req_ready), 32'h4);
        cycle();
        chk("bp_full_ready", 32'(req_ready), 32'h0);
        cycle();
        chk("bp_full_ready2", 32'(req_ready), 32'h0);
        chk("bp_full_data", 32'(out_data), 32'h00A0);
        cycle();
        chk("bp_full_ready3", 32'(req_ready), 32'h0);
        chk("bp_accepted", 32'(6 - rem[2]), 32'd2);
        drain();
        chk("bp_count", 32'(q_src.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk("bp_src", 32'(q_src[k]), 32'd2);
            chk("bp_data", 32'(q_data[k]), 32'(16'h00A0 + 16'(k)));
        end

        // Test 5: wrap-around from last_grant=3 gives source 0 first
        do_reset();
        rem[3] = 1;
        out_ready = 1'b1;
        drive_now();
        drain();
        q_src.delete();
        q_data.delete();
        rem[0] = 1;
        rem[3] = 1;
        drive_now();
        chk("wrap_ready", 32'(req_ready), 32'h1);
        cycle();
        chk("wrap_ready_next", 32'(req_ready), 32'h8);
        drain();
        chk("wrap_count", 32'(q_src.size()), 32'd2);
        chk("wrap_first", 32'(q_src[0]), 32'd0);
        chk("wrap_second", 32'(q_src[1]), 32'd3);

        // Test 6: random valid/ready with per-source scoreboard
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 50;
            exp_nxt[i] = nxt[i];
            waitc[i] = 0;
            maxw[i] = 0;
        end
        rnd = 1;
        vld = '0;
        apply();
        #1;
        c = 0;
        while (rem[0] + rem[1] + rem[2] + rem[3] != 0 && c < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle();
            c++;
        end
        chk("rnd_all_sent", 32'(rem[0] + rem[1] + rem[2] + rem[3]), 32'd0);
        drain();
        for (int i = 0; i < NREQ; i++) begin
            chk("rnd_delivered", 32'(exp_nxt[i]), 32'(((i + 1) << 12) + 50));
            chk("rnd_starve", 32'(maxw[i] <= NREQ), 32'd1);
        end
        rnd = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
